// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port read-only coefficient ROM among N_REQ
// requesters. One read is accepted per cycle over valid/ready. The ROM's fixed
// read latency is tracked with an ID pipeline, so each returned word is steered
// back to the requester that issued the read.
module rom_arbiter #(
  parameter int    N_REQ       = 4,
  parameter int    ADR_WIDTH   = 8,
  parameter int    DATA_WIDTH  = 16,
  parameter int    ROM_LATENCY = 2,
  parameter string ARB_MODE    = "RR"
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADR_WIDTH-1:0] req_adr,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [ADR_WIDTH-1:0]       rom_adr,
  input  logic [DATA_WIDTH-1:0]      rom_q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit IS_RR = (ARB_MODE == "RR");

  if (ARB_MODE != "RR" && ARB_MODE != "FIXED") begin : g_bad_mode
    $error("rom_arbiter: ARB_MODE must be \"RR\" or \"FIXED\"");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("rom_arbiter: N_REQ must be in 2..16");
  end
  if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_lat
    $error("rom_arbiter: ROM_LATENCY must be in 1..4");
  end

  // One ID pipeline stage: did a read issue, and for whom.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] id;
  } id_stage_t;

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [ADR_WIDTH-1:0] rom_adr_q, rom_adr_d;
  id_stage_t            pipe_q [ROM_LATENCY];
  id_stage_t            stage0_d;

  logic                 grant_any;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       cand_sum;
  logic [IDX_W-1:0]     cand;

  // Pick the winner: first valid requester at or after ptr (wrapping) in RR,
  // lowest valid index in FIXED. Grants are suppressed while in reset.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = (IS_RR ? {1'b0, ptr_q} : '0) + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (rst_n && !grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Decode the grant, advance the pointer past the winner, select the address
  // and build the stage-0 entry of the ID pipeline.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == IDX_W'(i));
    end
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    rom_adr_d = grant_any ? req_adr[grant_idx*ADR_WIDTH +: ADR_WIDTH] : rom_adr_q;
    stage0_d  = '{vld: grant_any, id: grant_idx};
  end

  assign rom_adr = rom_adr_d;

  // Priority pointer and held ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rom_adr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      ptr_q     <= ptr_d;
      rom_adr_q <= rom_adr_d;
    end
  end

  // ID pipeline matching the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is cleared, so reads in flight at reset never produce a response.
      for (int s = 0; s < ROM_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0_d;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  // Response steering: one-hot decode of the last stage, data straight from ROM.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = pipe_q[ROM_LATENCY-1].vld && (pipe_q[ROM_LATENCY-1].id == IDX_W'(i));
    end
  end

  assign rsp_data = rom_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: three instances (RR latency 2, FIXED latency 2,
// RR latency 1), each with its own ROM model and a behavioural reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NI = 3;
  localparam int LAT_OF [NI] = '{2, 2, 1};
  localparam bit FIX_OF [NI] = '{1'b0, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    valid   [NI];
  logic [N*AW-1:0] adr     [NI];
  logic [N-1:0]    ready   [NI];
  logic [N-1:0]    rv      [NI];
  logic [DW-1:0]   rdata   [NI];
  logic [DW-1:0]   rom_q   [NI];
  logic [AW-1:0]   rom_adr [NI];
  logic [AW-1:0]   apipe   [NI][4];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int            cyc = 0;
  int            ptr      [NI];
  logic [AW-1:0] last_adr [NI];
  bit            slot_v   [NI][8];
  int            slot_id  [NI][8];
  logic [DW-1:0] slot_dat [NI][8];
  logic [N-1:0]  last_grant [NI];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
    return 16'h0100 + DW'(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  rom_arbiter #(.N_REQ(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2), .ARB_MODE("RR")) u_rr2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_adr(adr[0]), .req_ready(ready[0]),
    .rsp_valid(rv[0]), .rsp_data(rdata[0]), .rom_adr(rom_adr[0]), .rom_q(rom_q[0]));

  rom_arbiter #(.N_REQ(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2), .ARB_MODE("FIXED")) u_fx2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_adr(adr[1]), .req_ready(ready[1]),
    .rsp_valid(rv[1]), .rsp_data(rdata[1]), .rom_adr(rom_adr[1]), .rom_q(rom_q[1]));

  rom_arbiter #(.N_REQ(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1), .ARB_MODE("RR")) u_rr1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid[2]), .req_adr(adr[2]), .req_ready(ready[2]),
    .rsp_valid(rv[2]), .rsp_data(rdata[2]), .rom_adr(rom_adr[2]), .rom_q(rom_q[2]));

  // ROM models: address registered LAT times, contents ROM[k] = k + 0x100.
  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      apipe[d][0] <= rom_adr[d];
      for (int k = 1; k < 4; k++) apipe[d][k] <= apipe[d][k-1];
    end
  end

  always_comb begin
    for (int d = 0; d < NI; d++) rom_q[d] = rom_word(apipe[d][LAT_OF[d]-1]);
  end

  // Compare process: at each falling edge derive expected outputs from the
  // arbitration rules, compare, then commit the effect of the coming edge.
  initial begin
    int            g, s, idx, base;
    logic [N-1:0]  e_ready, e_rv;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    for (int d = 0; d < NI; d++) begin
      ptr[d] = 0; last_adr[d] = '0; last_grant[d] = '0;
      for (int k = 0; k < 8; k++) slot_v[d][k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      s = cyc % 8;
      for (int d = 0; d < NI; d++) begin
        e_ready = '0; e_rv = '0; e_adr = '0; e_dat = '0; g = -1;
        if (!rst_n) begin
          ptr[d] = 0; last_adr[d] = '0; last_grant[d] = '0;
          for (int k = 0; k < 8; k++) slot_v[d][k] = 1'b0;
        end else begin
          base = FIX_OF[d] ? 0 : ptr[d];
          for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (g < 0 && valid[d][idx]) g = idx;
          end
          if (g >= 0) e_ready = N'(1) << g;
          e_adr = (g >= 0) ? adr[d][g*AW +: AW] : last_adr[d];
          if (slot_v[d][s]) begin
            e_rv  = N'(1) << slot_id[d][s];
            e_dat = slot_dat[d][s];
          end
        end
        check($sformatf("model ready[%0d]", d), ready[d], e_ready);
        check($sformatf("model rsp_valid[%0d]", d), rv[d], e_rv);
        check($sformatf("model rom_adr[%0d]", d), rom_adr[d], e_adr);
        if (e_rv != '0) check($sformatf("model rsp_data[%0d]", d), rdata[d], e_dat);
        if (rst_n) begin
          slot_v[d][s] = 1'b0;
          if (g >= 0) begin
            ptr[d]      = (g + 1) % N;
            last_adr[d] = e_adr;
            slot_v[d][(cyc + LAT_OF[d]) % 8]   = 1'b1;
            slot_id[d][(cyc + LAT_OF[d]) % 8]  = g;
            slot_dat[d][(cyc + LAT_OF[d]) % 8] = rom_word(e_adr);
          end
          last_grant[d] = e_ready;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < NI; d++) valid[d] = '0;
  endtask

  // Random requester obeying the hold-until-ready rule.
  task automatic random_req(int d);
    for (int i = 0; i < N; i++) begin
      if (valid[d][i]) begin
        if (last_grant[d][i]) begin
          if ($urandom_range(1, 0) == 1) valid[d][i] = 1'b0;
          else adr[d][i*AW +: AW] = AW'($urandom);
        end
      end else if ($urandom_range(9, 0) < 4) begin
        valid[d][i] = 1'b1;
        adr[d][i*AW +: AW] = AW'($urandom);
      end
    end
  endtask

  logic [N-1:0] rr_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < NI; d++) begin valid[d] = '0; adr[d] = '0; end
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset ready", ready[0], 4'b0000);
    check("reset rsp_valid", rv[0], 4'b0000);
    check("reset rom_adr", rom_adr[0], 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();

    // Single read: requester 2, address 0x05, response two cycles later.
    valid[0][2] = 1'b1; adr[0][2*AW +: AW] = 8'h05;
    @(negedge clk);
    check("single ready", ready[0], 4'b0100);
    check("single rom_adr", rom_adr[0], 8'h05);
    step(); valid[0] = '0;
    @(negedge clk); check("single gap", rv[0], 4'b0000);
    step();
    @(negedge clk);
    check("single rsp_valid", rv[0], 4'b0100);
    check("single rsp_data", rdata[0], 16'h0105);
    step();
    @(negedge clk); check("single after", rv[0], 4'b0000);

    // Wrap-around: ptr is 3; only requester 0 asks, then ptr = 1.
    step(); valid[0] = 4'b0001; adr[0][7:0] = 8'h40;
    @(negedge clk); check("wrap grant 0", ready[0], 4'b0001);
    step(); valid[0] = 4'b1000; adr[0][3*AW +: AW] = 8'h43;
    @(negedge clk); check("wrap grant 3", ready[0], 4'b1000);
    step(); valid[0] = 4'b1010; adr[0][1*AW +: AW] = 8'h41;
    @(negedge clk); check("wrap 1 before 3", ready[0], 4'b0010);
    step(); valid[0] = 4'b1000;
    @(negedge clk); check("wrap then 3", ready[0], 4'b1000);
    step(); valid[0] = '0;
    repeat (3) step();

    // Full contention in RR: grants 0,1,2,3,... back to back.
    adr[0] = {8'h13, 8'h12, 8'h11, 8'h10};
    valid[0] = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      @(negedge clk);
      check($sformatf("contend ready c%0d", c), ready[0], rr_seq[c % 4]);
      if (c >= 2) begin
        check($sformatf("contend rsp c%0d", c), rv[0], rr_seq[(c - 2) % 4]);
        check($sformatf("contend data c%0d", c), rdata[0], 16'h0110 + 16'((c - 2) % 4));
      end
    end
    step(); valid[0] = '0;
    repeat (3) step();

    // Reset mid-flight: grant requester 1, reset next cycle.
    valid[0] = 4'b0010; adr[0][1*AW +: AW] = 8'h55;
    @(negedge clk); check("midrst grant", ready[0], 4'b0010);
    step(); valid[0] = '0; rst_n = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step();
      @(negedge clk);
      check($sformatf("midrst rsp T+%0d", c), rv[0], 4'b0000);
    end
    step(); rst_n = 1'b1; valid[0] = 4'b0100; adr[0][2*AW +: AW] = 8'h33;
    @(negedge clk); check("post-reset grant", ready[0], 4'b0100);
    step(); valid[0] = '0;
    step();
    @(negedge clk);
    check("post-reset rsp", rv[0], 4'b0100);
    check("post-reset data", rdata[0], 16'h0133);
    repeat (2) step();

    // FIXED: requester 0 always beats 3; 3 wins once 0 drops.
    valid[1] = 4'b1001; adr[1] = {8'h63, 8'h00, 8'h00, 8'h60};
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      @(negedge clk);
      check($sformatf("fixed c%0d", c), ready[1], 4'b0001);
    end
    step(); valid[1] = 4'b1000;
    @(negedge clk); check("fixed starved wins", ready[1], 4'b1000);
    step(); valid[1] = '0;
    repeat (3) step();

    // Latency 1: back-to-back reads from 0 and 1.
    valid[2] = 4'b0011; adr[2] = {8'h00, 8'h00, 8'h21, 8'h20};
    @(negedge clk); check("lat1 grant 0", ready[2], 4'b0001);
    step(); valid[2] = 4'b0010;
    @(negedge clk);
    check("lat1 grant 1", ready[2], 4'b0010);
    check("lat1 rsp 0", rv[2], 4'b0001);
    check("lat1 data 0", rdata[2], 16'h0120);
    step(); valid[2] = '0;
    @(negedge clk);
    check("lat1 rsp 1", rv[2], 4'b0010);
    check("lat1 data 1", rdata[2], 16'h0121);
    step();
    @(negedge clk); check("lat1 idle", rv[2], 4'b0000);

    // Randomized traffic on all instances, with one reset pulse.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      for (int d = 0; d < NI; d++) random_req(d);
    end
    step(); idle_all();
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one single-port, read-only coefficient ROM among `N_REQ` requesters (FIR tap engines, coefficient loaders). It accepts at most one read per cycle over a valid/ready handshake and drives the ROM address. It tracks the ROM's fixed read latency with an ID pipeline and returns each read word to the requester that issued it. It sits directly in front of the single-port ROM instance; ROM latency is a parameter, so it serves both the registered block-RAM variant and the RTL variant.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `ADR_WIDTH`, 8, ROM address width
- `DATA_WIDTH`, 16, ROM data width
- `ROM_LATENCY`, 2, cycles from `rom_adr` to valid `rom_q` (2 for the M10K variant, 1 for the RTL variant; range 1..4)
- `ARB_MODE`, "RR", `"RR"` selects round-robin, `"FIXED"` selects fixed priority (index 0 highest); any other value is an elaboration `$error`
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous reset, active low
- `req_valid`  in  N_REQ  per-requester read request
- `req_adr`  in  N_REQ*ADR_WIDTH  per-requester address; requester i uses bits [i*ADR_WIDTH +: ADR_WIDTH]
- `req_ready`  out  N_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  N_REQ  one-hot; word for requester i is on `rsp_data`
- `rsp_data`  out  DATA_WIDTH  shared read-data bus
- `rom_adr`  out  ADR_WIDTH  to ROM address port
- `rom_q`  in  DATA_WIDTH  from ROM data port

## Operation
- Grant logic is combinational from `req_valid` and the priority pointer `ptr`. At most one bit of `req_ready` is set per cycle, and only for a requester with `req_valid` = 1.
- Round-robin: the first asserted `req_valid` at or after index `ptr`, scanning upward with wrap at N_REQ-1→0, wins.
- `ptr` is registered. After a grant to index i, `ptr` ← (i+1) mod N_REQ. With no grant, `ptr` holds.
- Fixed priority: the lowest asserted index wins, and `ptr` is unused.
- `rom_adr` is the granted requester's address. With no grant it holds its previous value, so `rom_adr` needs a register.
- ID pipeline: a shift register of depth ROM_LATENCY carrying {valid, id}. Stage 0 loads {grant_any, grant_idx} every cycle.
- `rsp_valid` is the one-hot decode of the last stage. It is 0 when that stage is invalid.
- `rsp_data` = `rom_q`, passed through combinationally. It is meaningful only while some `rsp_valid` bit is set.
- Requester rules: once `req_valid` is asserted, the requester holds it and `req_adr` stable until `req_ready`. It may deassert only after the transfer.
- The arbiter never stalls on response. Requesters must accept `rsp_valid` in the cycle it appears.
- Requester throughput: under full contention, each requester gets one grant per N_REQ cycles in RR mode. In FIXED mode, lower-priority requesters may starve (documented behaviour).

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - `ptr` = 0, `rom_adr` = 0, all pipeline valid bits = 0.
  - Hence `rsp_valid` = 0 immediately, and `req_ready` = 0 while `rst_n` = 0 (grants gated by reset).
- Throughput: one transfer per cycle with back-to-back grants and no bubbles.
- Latency: a transfer in cycle T produces `rsp_valid[i]` = 1 in cycle T+ROM_LATENCY, with `rsp_data` = ROM[addr].
- Simultaneous events: a new grant and a response for the same or a different requester in the same cycle are independent, and both occur.
- Wrap-around: with `ptr` = N_REQ-1 and only requester 0 requesting, requester 0 is granted and `ptr` becomes 1.
- Reset mid-operation: all in-flight reads are discarded, and no `rsp_valid` is produced for them after reset release. The first grant is possible in the first cycle with `rst_n` = 1.
- No combinational path from `rom_q` to `req_ready`. There is a combinational path from `req_valid` to `req_ready`, `rom_adr` and the stage-0 input only.

## Test plan
- Single read, ROM_LATENCY=2, ROM[k]=k+0x100: requester 2 requests adr 0x05 at cycle 10 → `req_ready[2]`=1 at cycle 10; `rsp_valid`=4'b0100 and `rsp_data`=0x0105 at cycle 12; all other cycles have `rsp_valid`=0.
- Full contention, RR, all four hold valid with adr = 0x10+i → grants in order 0,1,2,3,0,…, one per cycle; responses follow in the same order, 2 cycles later, with data ROM[0x10+i]; no idle cycles.
- Wrap-around: make requester 3 the last granted, so `ptr`=0; then 3 and 1 request → 1 granted first, then 3. Separately, after a grant to 3, `ptr` reads 0.
- FIXED mode, requesters 0 and 3 valid continuously for 20 cycles → requester 0 granted every cycle and requester 3 never; after 0 drops, requester 3 is granted the next cycle.
- Reset mid-flight: grant requester 1 at cycle T and assert `rst_n`=0 at T+1 → `rsp_valid` stays 0 through T+5; after release, a new request is granted on the first cycle with `rst_n`=1.
- ROM_LATENCY=1 build with the RTL ROM: back-to-back reads from requesters 0 and 1 return ROM words exactly 1 cycle after each grant, with the correct one-hot `rsp_valid`.
